// File: rtl/c17_capture_aligner_if.sv
// c17_capture_aligner_if: vector-issue, netlist-output, result-stream and status bundle for the c17 capture stage
interface c17_capture_aligner_if #(parameter int TAG_W = 8);
  logic in_valid, in_ready, n22_in, n23_in, out_valid, out_ready, overflow;
  logic [1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [7:0] drop_count;
  modport master(output in_valid, n22_in, n23_in, out_ready,
                 input in_ready, out_valid, out_data, out_tag, overflow, drop_count);
  modport slave(input in_valid, n22_in, n23_in, out_ready,
                output in_ready, out_valid, out_data, out_tag, overflow, drop_count);
endinterface

// File: rtl/c17_capture_aligner.sv
// c17_capture_aligner: realigns skewed c17 outputs to their vector, tags them and buffers them in a credit-guarded FIFO
module c17_capture_aligner #(
  parameter int LAT_N22 = 5,
  parameter int LAT_N23 = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input logic clk,
  input logic rst,
  c17_capture_aligner_if.slave bus
);
  localparam int SKEW = LAT_N22 - LAT_N23;
  localparam int AW = $clog2(DEPTH);
  logic [TAG_W-1:0] r_tag;
  logic [LAT_N22-1:0] r_pv;
  logic [TAG_W-1:0] r_pt [LAT_N22];
  logic [1:0] r_md [DEPTH];
  logic [TAG_W-1:0] r_mt [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_occ;
  logic r_ovf;
  logic [7:0] r_drop;
  logic [SKEW:0] w_sk;
  logic w_push, w_pop, w_full, w_wr, w_drop;
  int w_load;
  assign w_sk[0] = bus.n23_in;
  for (genvar g = 0; g < SKEW; g++) begin : g_skew
    logic r_s;
    always_ff @(posedge clk) r_s <= rst ? 1'b0 : w_sk[g];
    assign w_sk[g+1] = r_s;
  end
  always_comb begin
    w_push = r_pv[LAT_N22-1];
    w_full = r_occ == (AW+1)'(DEPTH);
    w_pop = (r_occ != '0) && bus.out_ready;
    w_wr = w_push && (!w_full || w_pop);
    w_drop = w_push && w_full && !w_pop;
    w_load = int'(r_occ);
    for (int i = 0; i < LAT_N22; i++) w_load += int'(r_pv[i]);
  end
  assign bus.in_ready = w_load < DEPTH;
  assign bus.out_valid = r_occ != '0;
  assign bus.out_data = bus.out_valid ? r_md[r_rp] : 2'b00;
  assign bus.out_tag = bus.out_valid ? r_mt[r_rp] : '0;
  assign bus.overflow = r_ovf;
  assign bus.drop_count = r_drop;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
      r_pv <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_occ <= '0;
      r_ovf <= 1'b0;
      r_drop <= '0;
    end else begin
      if (bus.in_valid) r_tag <= r_tag + 1'b1;
      r_pv <= LAT_N22'({r_pv, bus.in_valid});
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_occ <= r_occ + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hff) r_drop <= r_drop + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    r_pt[0] <= r_tag;
    for (int i = 1; i < LAT_N22; i++) r_pt[i] <= r_pt[i-1];
    if (w_wr) begin
      r_md[r_wp] <= {bus.n22_in, w_sk[SKEW]};
      r_mt[r_wp] <= r_pt[LAT_N22-1];
    end
  end
endmodule

// File: tb/tb_c17_capture_aligner.sv
// tb_c17_capture_aligner: randomized scoreboard bench for the c17 capture aligner
module tb_c17_capture_aligner;
  localparam int L22 = 5, L23 = 4, D = 4, TW = 8;
  typedef struct {int due; logic [TW-1:0] tag; logic [1:0] d;} res_t;
  logic clk = 0, rst = 1;
  c17_capture_aligner_if #(.TAG_W(TW)) bus();
  c17_capture_aligner #(.LAT_N22(L22), .LAT_N23(L23), .DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0, m_occ = 0, m_drop = 0, checks = 0, passes = 0, n_acc = 0, lat;
  bit m_ovf = 0, mon_en = 0, junk = 0;
  logic [TW-1:0] m_tag = 0;
  logic [1:0] cur_d = 0;
  res_t flight[$], exp_q[$];
  logic [TW+1:0] pops[$];
  bit n22_at[int], n23_at[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic logic [1:0] c17(input logic [4:0] n);
    logic n10, n11, n16, n19;
    n10 = ~(n[4] & n[2]);
    n11 = ~(n[2] & n[1]);
    n16 = ~(n[3] & n11);
    n19 = ~(n11 & n[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  task automatic step(input bit v, input bit r, input bit resp, input logic [4:0] nv, input bit rs);
    @(posedge clk); #1;
    rst = rs;
    bus.out_ready = r;
    bus.in_valid = v && (!resp || bus.in_ready);
    bus.n22_in = n22_at.exists(cyc + 1) ? n22_at[cyc + 1] : (junk ? 1'($urandom) : 1'b0);
    bus.n23_in = n23_at.exists(cyc + 1) ? n23_at[cyc + 1] : (junk ? 1'($urandom) : 1'b0);
    cur_d = c17(nv);
    if (bus.in_valid) begin
      n_acc++;
      n22_at[cyc + 1 + L22] = cur_d[1];
      n23_at[cyc + 1 + L23] = cur_d[0];
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, r, 0, 5'd0, 0);
  endtask

  task automatic do_reset(input bit r);
    step(0, r, 0, 5'd0, 1);
    step(0, r, 0, 5'd0, 0);
  endtask

  always @(posedge clk) begin
    bit pop;
    res_t r;
    cyc++;
    if (rst) begin
      flight.delete();
      exp_q.delete();
      m_occ = 0;
      m_drop = 0;
      m_ovf = 0;
      m_tag = 0;
    end else begin
      pop = m_occ > 0 && bus.out_ready;
      if (flight.size() > 0 && flight[0].due == cyc) begin
        r = flight.pop_front();
        if (m_occ < D || pop) begin
          exp_q.push_back(r);
          m_occ++;
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (pop) m_occ--;
      if (bus.in_valid) begin
        flight.push_back('{cyc + L22, m_tag, cur_d});
        m_tag++;
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    chk("out_valid", bus.out_valid, m_occ > 0);
    chk("in_ready", bus.in_ready, (m_occ + flight.size()) < D);
    chk("overflow", bus.overflow, m_ovf);
    chk("drop_count", bus.drop_count, m_drop);
    if (bus.out_valid) begin
      chk("head_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        chk("head_data", bus.out_data, exp_q[0].d);
        chk("head_tag", bus.out_tag, exp_q[0].tag);
        if (bus.out_ready) begin
          pops.push_back({bus.out_data, bus.out_tag});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.in_valid = 0; bus.out_ready = 0; bus.n22_in = 0; bus.n23_in = 0;
    step(0, 0, 0, 5'd0, 1);
    step(0, 0, 0, 5'd0, 1);
    step(0, 0, 0, 5'd0, 0);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    mon_en = 1;

    pops.delete();
    lat = 0;
    step(1, 1, 1, 5'b10100, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 5'd0, 0);
      @(negedge clk);
      if (bus.out_valid) begin lat = i; break; end
    end
    chk("single_latency", lat, 6);
    idle(3, 1);
    chk("single_count", pops.size(), 1);
    if (pops.size() == 1) chk("single_result", pops[0], {2'b10, 8'd0});

    pops.delete();
    step(1, 1, 1, 5'b00001, 0);
    idle(9, 1);
    chk("skew_count", pops.size(), 1);
    if (pops.size() == 1) chk("skew_data", pops[0][TW+1:TW], 2'b01);

    junk = 1;
    do_reset(1);
    pops.delete();
    for (int i = 0; i < 20; i++) step(1, 1, 0, 5'($urandom), 0);
    idle(10, 1);
    chk("stream_count", pops.size(), 20);
    for (int i = 0; i < 20 && i < pops.size(); i++) chk("stream_tag", pops[i][TW-1:0], i);
    chk("stream_overflow", bus.overflow, 0);

    do_reset(0);
    n_acc = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 1, 5'($urandom), 0);
    @(negedge clk);
    chk("credit_in_ready", bus.in_ready, 0);
    chk("credit_accepted", n_acc, 4);
    idle(6, 0);
    @(negedge clk);
    chk("credit_overflow", bus.overflow, 0);
    pops.delete();
    idle(6, 1);
    chk("credit_buffered", pops.size(), 4);

    do_reset(0);
    pops.delete();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 5'($urandom), 0);
    idle(8, 0);
    @(negedge clk);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_drops", bus.drop_count, 2);
    idle(6, 1);
    chk("ovf_drain_count", pops.size(), 4);
    for (int i = 0; i < 4 && i < pops.size(); i++) chk("ovf_drain_tag", pops[i][TW-1:0], i);

    for (int i = 0; i < 5; i++) step(1, 0, 0, 5'($urandom), 0);
    idle(2, 0);
    do_reset(0);
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_drop_count", bus.drop_count, 0);
    pops.delete();
    idle(12, 1);
    chk("midrst_stale", pops.size(), 0);

    do_reset(1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 0);
    idle(12, 1);
    @(negedge clk);
    chk("random_drained", exp_q.size(), 0);

    do_reset(0);
    for (int i = 0; i < 270; i++) step(1, 0, 0, 5'($urandom), 0);
    idle(8, 0);
    @(negedge clk);
    chk("drop_saturate", bus.drop_count, 255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/c17_capture_aligner.md
# c17_capture_aligner

Downstream capture stage for the path-balanced, clocked c17 netlist. N22 and N23 leave the netlist at different depths (5 and 4 stages), and the netlist cannot stall. This block realigns the two outputs to the vector that produced them, tags each result with a sequence number and buffers results in a small FIFO with a ready/valid output. A credit-style `in_ready` lets the upstream vector source throttle, so results are never lost when that rule is respected.

## Interface
- `LAT_N22`, 5, stages from vector issue to N22; must be ≥ `LAT_N23`, ≥1
- `LAT_N23`, 4, stages from vector issue to N23; ≥1
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `TAG_W`, 8, sequence tag width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  a vector enters the c17 netlist this cycle
- `in_ready`  out  1  upstream may issue a vector this cycle
- `n22_in`  in  1  netlist output N22
- `n23_in`  in  1  netlist output N23
- `out_valid`  out  1  FIFO head holds a result
- `out_ready`  in  1  consumer accepts the head this cycle
- `out_data`  out  2  `{N22, N23}` of the head result
- `out_tag`  out  TAG_W  sequence number of the head result
- `overflow`  out  1  sticky; a result was dropped
- `drop_count`  out  8  dropped results, saturates at 255

## Operation
- Tag counter: increments (mod 2^TAG_W) on every cycle with `in_valid`=1, whether or not `in_ready` is high. The current value is the tag of the vector issued that cycle.
- Valid/tag pipeline: `LAT_N22` stages of {valid, tag}, entered with {`in_valid`, tag counter}.
- N23 skew line: `LAT_N22`−`LAT_N23` registers delay `n23_in`. When the two latencies are equal, it is a wire.
- Aligned push: when the last pipeline stage is valid, the result is written as `{n22_in, delayed n23}` with its tag.
- FIFO: circular buffer of `DEPTH` entries.
  - Pop when `out_valid`&`out_ready`.
  - A push while full succeeds only if a pop occurs in the same cycle.
  - Otherwise the push is dropped: `overflow`←1 and `drop_count` increments, saturating.
- `in_ready` = (occupancy + count of valid bits in the pipeline) < `DEPTH`.
  - Computed combinationally from registers only; it is independent of `out_ready`.
- No FSM beyond the FIFO pointers.
- The occupancy counter is `$clog2(DEPTH)+1` bits wide. Pointers wrap modulo `DEPTH`.

## Timing
- Reset, synchronous: pipeline valids, skew line, pointers, occupancy, tag counter, `overflow` and `drop_count` all go to 0.
  - After reset: `out_valid`=0, `out_data`=0, `out_tag`=0, `in_ready`=1.
  - Reset during traffic discards all in-flight and buffered results. The netlist outputs that arrive later are ignored, because their valids were cleared.
- Latency: a vector issued in cycle t (`in_valid`=1 sampled at edge t) pairs `n22_in` sampled at edge t+`LAT_N22` with `n23_in` sampled at edge t+`LAT_N23`. It is written at edge t+`LAT_N22`, and `out_valid`=1 from cycle t+`LAT_N22`+1 if the FIFO was empty.
- Throughput: one result per cycle in and one out.
- `out_data`/`out_tag` hold stable while `out_valid`=1 and `out_ready`=0.
- Full FIFO, simultaneous push and pop: the pop takes the old head, the push lands at the tail, and occupancy is unchanged.
- Empty FIFO with `out_ready`=1: no pop and no state change. There is no same-cycle bypass from push to output.
- `in_ready` drops the cycle after occupancy plus in-flight count reaches `DEPTH`.

## Test plan
- Single vector: N1..N7=1,0,1,0,0 issued at cycle 0 with tag 0; netlist gives N22=1 at cycle 5 and N23=0 at cycle 4. Required: `out_valid` rises at cycle 6 with `out_data`=2'b10 and `out_tag`=0.
- Skew check: bench drives `n23_in`=1 only at cycle 4 and `n22_in`=0 at cycle 5 for a vector issued at cycle 0. Required: result is 2'b01; a result of 2'b00 means the skew line is wrong.
- Back-to-back stream with `out_ready`=1: 20 consecutive vectors. Required: results come out in order with tags 0..19, one per cycle, and `overflow`=0.
- Credit throttling with `out_ready`=0: issue vectors only while `in_ready`=1. Required: exactly 4 accepted, `in_ready`=0 from the cycle after the 4th issue, 4 results buffered, and `overflow`=0.
- Forced overflow with `out_ready`=0: 6 vectors issued while ignoring `in_ready`. Required: tags 0..3 buffered, `overflow`=1, `drop_count`=2; draining yields tags 0,1,2,3.
- Reset mid-stream: assert `rst` for 1 cycle with 3 results in flight and 2 buffered. Required: `out_valid`=0, `in_ready`=1 and `drop_count`=0 afterward, and no stale results appear later.
